cu_seq: RTL and testbench
=========================

# cu_seq

Parametrised, self-sequencing control unit for the Mini-CPU; it replaces the fixed 8-register CU, which depends on an external step counter. It owns the step counter and a FETCH/EXEC/HALT state machine, and decodes opcode and operand into one-hot register strobes sized by `NUM_REGS`. It also drives the datapath strobes for PC, MAR, MDR, CIR, AR, RAM and flags. Conditional-jump and instruction-length behaviour is uniform per instruction class.

## Interface
- `DATA_W`, 8: operand/AR width; must satisfy `DATA_W >= 2 + 2*RSEL_W`.
- `NUM_REGS`, 8: register-file size; `RSEL_W = $clog2(NUM_REGS)`.
- `ACC_IDX`, 2: index of the accumulator (register C).
- `STEP_W`, 4: step counter width; must be at least 4.
- `TRAP_VEC`, 8'hF0: trap target address (`DATA_W` bits); used only with `CU_TRAP_EN`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpu_run` in 1: run enable.
- `opcode` in 8: from CIR.
- `operand` in `DATA_W`: from AR; fields mode=`[2*RSEL_W+1 -: 2]`, dest=`[2*RSEL_W-1 -: RSEL_W]`, src=`[RSEL_W-1:0]`.
- `Z`, `N`, `C`, `V` in 1 each: flags.
- `step` out `STEP_W`: current step.
- `reg_in`, `reg_out` out `NUM_REGS`: one-hot register load and drive strobes.
- `acc_sel` out 1: accumulator takes bus, not ALU.
- `alu_op` out 4: `opcode[3:0]`, valid whenever state is EXEC.
- `PC_out`, `PC_inc`, `PC_in`, `MAR_in`, `MDR_in`, `CIR_in`, `CIR_out`, `AR_in`, `AR_out`, `RAM_in`, `RAM_out`, `flag_in` out 1 each: datapath strobes.
- `HALT` out 1: halted.
- `trap` out 1: trap strobe.
- `vec_out` out `DATA_W`: trap vector onto bus.

## Operation
- Registered state: `state` ∈ {FETCH, EXEC, HALTED} and `step`. All outputs are combinational decodes of the registered state, `step`, `opcode`, `operand` and the flags.
- Strobes are 0 whenever `cpu_run`=0 or `rst_n`=0. `step` and `state` hold while `cpu_run`=0.
- FETCH, one step per cycle:
  - step 0: `PC_out`, `MAR_in`
  - step 1: `MDR_in`
  - step 2: `CIR_in`
  - step 3: `PC_inc`
  - step 4: `CIR_out`, `AR_in`; then state becomes EXEC, step 5.
- EXEC: each instruction has a last step. On the last step, step goes to 0 and state to FETCH the next cycle; otherwise step increments. No step beyond the last step exists.
- Register operand valid only if mode = 2'b01. With another mode, no register strobes are driven, but instruction length is unchanged.

Instruction classes (opcode: steps, last step):
- 00–05, two-operand ALU:
  - step 5: `reg_out[src]`, `reg_in[dest]`
  - step 6: `flag_in`; last step 6.
- 06–0C, unary on accumulator:
  - step 5: `reg_in[ACC_IDX]`
  - step 6: `flag_in`; last step 6.
- 0D, NOP: step 5, no strobes; last step 5.
- 0E, HLT: step 5 asserts nothing, and state becomes HALTED.
- 0F, LOAD:
  - step 5: `AR_out`, `RAM_out`
  - step 6: `RAM_out`, `reg_in[ACC_IDX]`, `acc_sel`
  - step 7: `flag_in`; last step 7.
- 10, STORE: step 5: `AR_out`, `reg_out[ACC_IDX]`, `RAM_in`; last step 5.
- 11, MOV R,C: step 5: `reg_out[src]`, `reg_in[dest]`; last step 5.
- 12, MOV C,R:
  - step 5: `reg_out[src]`, `reg_in[ACC_IDX]`, `acc_sel`
  - step 6: `flag_in`; last step 6.
- 13, MOVI:
  - step 5: `AR_out`, `reg_in[ACC_IDX]`, `acc_sel`
  - step 6: `flag_in`; last step 6.
- 14, JMP: step 5: `AR_out`, `PC_in`; last step 5.
- 15–1C, conditional jumps on Z, !Z, C, !C, !N, N, V, !V:
  - The condition is sampled at step 5. If taken, assert `AR_out` and `PC_in`; if not taken, no strobes.
  - Last step 5 in both cases.
- 1D–FF: handled per Configuration.

HALTED state:
- `HALT`=1 and `step` holds at 5.
- No other strobes are driven.
- Exit is by `rst_n` only.

## Timing
- Reset (asynchronous): state=FETCH, `step`=0. All outputs are 0 while `rst_n`=0, including `HALT`, `trap` and `vec_out`.
- On the first rising edge after release with `cpu_run`=1, the step 0 strobes are already visible (combinational).
- Instruction length in cycles is last step + 1: 6 (NOP, STORE, MOV R,C, JMP, Jcc), 7 (ALU, MOV C,R, MOVI), 8 (LOAD). HLT enters HALTED on the step 5 → next edge.
- `cpu_run` dropping mid-instruction freezes the step. Resuming continues at the same step with the same strobes.
- Reset mid-instruction aborts immediately; no partial strobes persist.
- Flags are sampled combinationally during step 5, so a flag update in the previous instruction's `flag_in` cycle is visible.

## Configuration
- `CU_TRAP_EN` defined: opcodes 1D–FF, and register-operand instructions with mode ≠ 01, trap at step 5 instead of their normal step 5 action:
  - `trap`=1, `PC_in`=1, `vec_out`=`TRAP_VEC`
  - last step 5.
- `CU_TRAP_EN` undefined:
  - Opcodes 1D–FF behave as NOP (6 cycles).
  - Bad-mode operands behave as stated in Operation.
  - `trap`=0 and `vec_out`=0 always.

## Test plan
- Reset: `rst_n`=0 mid-step 6 of ADD → all outputs 0 and `step`=0 immediately. After release with `cpu_run`=1 → `PC_out`=`MAR_in`=1.
- ADD, operand 8'b01_011_001 → step 5 `reg_out`=8'h02, `reg_in`=8'h08; step 6 `flag_in`; step 0 seven cycles after the previous step 0.
- JZ with Z=0 and with Z=1 → not taken: no `PC_in` and 6 cycles. Taken: `PC_in`=`AR_out`=1 at step 5 and 6 cycles.
- LOAD → `RAM_out` asserted at steps 5 and 6, `acc_sel` and `reg_in[2]` at step 6, `flag_in` at step 7, 8 cycles total. `cpu_run`=0 for 3 cycles at step 6 → step holds and strobes are 0.
- HLT → `HALT`=1 from step 5 onward, held for 20 cycles with no other strobes, cleared only by `rst_n`.
- Opcode 8'h3F → with `CU_TRAP_EN`: `trap`=1, `vec_out`=8'hF0 and `PC_in` at step 5. Without it: NOP, 6 cycles, `trap`=0.

Source files
------------

// File: rtl/cu_seq.sv
// Self-sequencing Mini-CPU control unit: owns the step counter and FETCH/EXEC/HALTED FSM.
// Define CU_TRAP_EN to trap undefined opcodes and bad-mode register operands to TRAP_VEC.
module cu_seq #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int ACC_IDX  = 2,
  parameter int STEP_W   = 4,
  parameter logic [DATA_W-1:0] TRAP_VEC = DATA_W'(8'hF0)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_run,
  input  logic [7:0]          opcode,
  input  logic [DATA_W-1:0]   operand,
  input  logic                Z,
  input  logic                N,
  input  logic                C,
  input  logic                V,
  output logic [STEP_W-1:0]   step,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic                acc_sel,
  output logic [3:0]          alu_op,
  output logic                PC_out,
  output logic                PC_inc,
  output logic                PC_in,
  output logic                MAR_in,
  output logic                MDR_in,
  output logic                CIR_in,
  output logic                CIR_out,
  output logic                AR_in,
  output logic                AR_out,
  output logic                RAM_in,
  output logic                RAM_out,
  output logic                flag_in,
  output logic                HALT,
  output logic                trap,
  output logic [DATA_W-1:0]   vec_out
);

  localparam int RSEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [STEP_W-1:0] ST0 = STEP_W'(0);
  localparam logic [STEP_W-1:0] ST1 = STEP_W'(1);
  localparam logic [STEP_W-1:0] ST2 = STEP_W'(2);
  localparam logic [STEP_W-1:0] ST3 = STEP_W'(3);
  localparam logic [STEP_W-1:0] ST4 = STEP_W'(4);
  localparam logic [STEP_W-1:0] ST5 = STEP_W'(5);
  localparam logic [STEP_W-1:0] ST6 = STEP_W'(6);
  localparam logic [STEP_W-1:0] ST7 = STEP_W'(7);

`ifdef CU_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALTED} state_e;

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;

  logic [1:0]          mode;
  logic [RSEL_W-1:0]   dest, src;
  logic [NUM_REGS-1:0] dest_oh, src_oh, acc_oh;
  logic                reg_ok, is_regop, is_trap, jcc_take;
  logic                is_alu2, is_unary, is_jcc;
  logic [STEP_W-1:0]   last_step;

  assign mode    = operand[2*RSEL_W+1 -: 2];
  assign dest    = operand[2*RSEL_W-1 -: RSEL_W];
  assign src     = operand[RSEL_W-1:0];
  assign dest_oh = NUM_REGS'(1) << dest;
  assign src_oh  = NUM_REGS'(1) << src;
  assign acc_oh  = NUM_REGS'(1) << ACC_IDX;

  assign is_alu2  = (opcode <= 8'h05);
  assign is_unary = (opcode >= 8'h06) && (opcode <= 8'h0C);
  assign is_jcc   = (opcode >= 8'h15) && (opcode <= 8'h1C);
  assign reg_ok   = (mode == 2'b01);
  assign is_regop = is_alu2 || (opcode == 8'h11) || (opcode == 8'h12);
  assign is_trap  = TrapEn && ((opcode >= 8'h1D) || (is_regop && !reg_ok));

  always_comb begin
    jcc_take = 1'b0;
    case (opcode)
      8'h15: jcc_take = Z;
      8'h16: jcc_take = !Z;
      8'h17: jcc_take = C;
      8'h18: jcc_take = !C;
      8'h19: jcc_take = !N;
      8'h1A: jcc_take = N;
      8'h1B: jcc_take = V;
      8'h1C: jcc_take = !V;
      default: jcc_take = 1'b0;
    endcase
  end

  // Instruction length by class; trapped instructions all end at step 5
  always_comb begin
    last_step = ST5;
    if (!is_trap) begin
      if (opcode == 8'h0F)
        last_step = ST7;
      else if (is_alu2 || is_unary || (opcode == 8'h12) || (opcode == 8'h13))
        last_step = ST6;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      step_q  <= ST0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    if (cpu_run) begin
      case (state_q)
        S_FETCH: begin
          if (step_q == ST4) begin
            state_d = S_EXEC;
            step_d  = ST5;
          end else begin
            step_d = step_q + ST1;
          end
        end
        S_EXEC: begin
          if (opcode == 8'h0E) begin
            state_d = S_HALTED;
          end else if (step_q >= last_step) begin
            state_d = S_FETCH;
            step_d  = ST0;
          end else begin
            step_d = step_q + ST1;
          end
        end
        default: ;
      endcase
    end
  end

  assign step = step_q;

  always_comb begin
    reg_in  = '0;
    reg_out = '0;
    acc_sel = 1'b0;
    alu_op  = 4'h0;
    PC_out  = 1'b0;
    PC_inc  = 1'b0;
    PC_in   = 1'b0;
    MAR_in  = 1'b0;
    MDR_in  = 1'b0;
    CIR_in  = 1'b0;
    CIR_out = 1'b0;
    AR_in   = 1'b0;
    AR_out  = 1'b0;
    RAM_in  = 1'b0;
    RAM_out = 1'b0;
    flag_in = 1'b0;
    HALT    = 1'b0;
    trap    = 1'b0;
    vec_out = '0;
    if (rst_n) begin
      HALT = (state_q == S_HALTED);
      if (state_q == S_EXEC) alu_op = opcode[3:0];
    end
    if (rst_n && cpu_run) begin
      case (state_q)
        S_FETCH: begin
          case (step_q)
            ST0: begin PC_out = 1'b1; MAR_in = 1'b1; end
            ST1: MDR_in = 1'b1;
            ST2: CIR_in = 1'b1;
            ST3: PC_inc = 1'b1;
            ST4: begin CIR_out = 1'b1; AR_in = 1'b1; end
            default: ;
          endcase
        end
        S_EXEC: begin
          if (is_trap) begin
            if (step_q == ST5) begin
              trap    = 1'b1;
              PC_in   = 1'b1;
              vec_out = TRAP_VEC;
            end
          end else if (is_alu2) begin
            if (step_q == ST5 && reg_ok) begin reg_out = src_oh; reg_in = dest_oh; end
            if (step_q == ST6) flag_in = 1'b1;
          end else if (is_unary) begin
            if (step_q == ST5) reg_in = acc_oh;
            if (step_q == ST6) flag_in = 1'b1;
          end else if (opcode == 8'h0F) begin
            if (step_q == ST5) begin AR_out = 1'b1; RAM_out = 1'b1; end
            if (step_q == ST6) begin RAM_out = 1'b1; reg_in = acc_oh; acc_sel = 1'b1; end
            if (step_q == ST7) flag_in = 1'b1;
          end else if (opcode == 8'h10) begin
            if (step_q == ST5) begin AR_out = 1'b1; reg_out = acc_oh; RAM_in = 1'b1; end
          end else if (opcode == 8'h11) begin
            if (step_q == ST5 && reg_ok) begin reg_out = src_oh; reg_in = dest_oh; end
          end else if (opcode == 8'h12) begin
            if (step_q == ST5 && reg_ok) begin reg_out = src_oh; reg_in = acc_oh; acc_sel = 1'b1; end
            if (step_q == ST6) flag_in = 1'b1;
          end else if (opcode == 8'h13) begin
            if (step_q == ST5) begin AR_out = 1'b1; reg_in = acc_oh; acc_sel = 1'b1; end
            if (step_q == ST6) flag_in = 1'b1;
          end else if (opcode == 8'h14 || (is_jcc && jcc_take)) begin
            if (step_q == ST5) begin AR_out = 1'b1; PC_in = 1'b1; end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cu_seq.sv
// Randomised bench for cu_seq against a per-instruction table model of the control sequence.
module tb_cu_seq;
  localparam int DATA_W = 8, NUM_REGS = 8, STEP_W = 4;

`ifdef CU_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, cpu_run, Z, N, C, V;
  logic [7:0] opcode;
  logic [DATA_W-1:0] operand;
  logic [STEP_W-1:0] step;
  logic [NUM_REGS-1:0] reg_in, reg_out;
  logic acc_sel, PC_out, PC_inc, PC_in, MAR_in, MDR_in, CIR_in, CIR_out;
  logic AR_in, AR_out, RAM_in, RAM_out, flag_in, HALT, trap;
  logic [3:0] alu_op;
  logic [DATA_W-1:0] vec_out;

  cu_seq dut (
    .clk(clk), .rst_n(rst_n), .cpu_run(cpu_run), .opcode(opcode), .operand(operand),
    .Z(Z), .N(N), .C(C), .V(V), .step(step), .reg_in(reg_in), .reg_out(reg_out),
    .acc_sel(acc_sel), .alu_op(alu_op), .PC_out(PC_out), .PC_inc(PC_inc), .PC_in(PC_in),
    .MAR_in(MAR_in), .MDR_in(MDR_in), .CIR_in(CIR_in), .CIR_out(CIR_out), .AR_in(AR_in),
    .AR_out(AR_out), .RAM_in(RAM_in), .RAM_out(RAM_out), .flag_in(flag_in), .HALT(HALT),
    .trap(trap), .vec_out(vec_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pc_out, pc_inc, pc_in, mar_in, mdr_in, cir_in, cir_out, ar_in;
    logic ar_out, ram_in, ram_out, flag_in, acc_sel, trap, halt;
    logic [7:0] rin, rout, vec;
    logic [3:0] alu, stp;
  } obs_t;

  int n_cmp = 0, n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    o = '{pc_out: PC_out, pc_inc: PC_inc, pc_in: PC_in, mar_in: MAR_in, mdr_in: MDR_in,
          cir_in: CIR_in, cir_out: CIR_out, ar_in: AR_in, ar_out: AR_out, ram_in: RAM_in,
          ram_out: RAM_out, flag_in: flag_in, acc_sel: acc_sel, trap: trap, halt: HALT,
          rin: reg_in, rout: reg_out, vec: vec_out, alu: alu_op, stp: step};
    return o;
  endfunction

  function automatic bit traps(input logic [7:0] op, input logic [7:0] opnd);
    bit regop = (op <= 8'h05) || op == 8'h11 || op == 8'h12;
    return TRAP_ON && (op >= 8'h1D || (regop && opnd[7:6] != 2'b01));
  endfunction

  // Cycles per instruction, from the class table (HLT counted up to its step 5)
  function automatic int ilen(input logic [7:0] op, input logic [7:0] opnd);
    if (traps(op, opnd)) return 6;
    if (op == 8'h0F) return 8;
    if (op <= 8'h0C || op == 8'h12 || op == 8'h13) return 7;
    return 6;
  endfunction

  function automatic obs_t model(input logic [7:0] op, input logic [7:0] opnd,
                                 input logic [3:0] f, input int k, input bit run);
    obs_t o;
    bit ok, take;
    logic [7:0] s1h, d1h;
    logic z, n, c, v;
    {z, n, c, v} = f;
    o = '0;
    o.stp = 4'(k);
    if (k >= 5) o.alu = op[3:0];
    if (!run) return o;
    ok  = (opnd[7:6] == 2'b01);
    s1h = 8'(1) << opnd[2:0];
    d1h = 8'(1) << opnd[5:3];
    case (k)
      0: begin o.pc_out = 1; o.mar_in = 1; end
      1: o.mdr_in = 1;
      2: o.cir_in = 1;
      3: o.pc_inc = 1;
      4: begin o.cir_out = 1; o.ar_in = 1; end
      default: ;
    endcase
    if (k < 5) return o;
    if (traps(op, opnd)) begin
      if (k == 5) begin o.trap = 1; o.pc_in = 1; o.vec = 8'hF0; end
      return o;
    end
    take = (op == 8'h14) || (op == 8'h15 && z) || (op == 8'h16 && !z) || (op == 8'h17 && c) ||
           (op == 8'h18 && !c) || (op == 8'h19 && !n) || (op == 8'h1A && n) ||
           (op == 8'h1B && v) || (op == 8'h1C && !v);
    if (op <= 8'h05) begin
      if (k == 5 && ok) begin o.rout = s1h; o.rin = d1h; end
      if (k == 6) o.flag_in = 1;
    end else if (op <= 8'h0C) begin
      if (k == 5) o.rin = 8'h04;
      if (k == 6) o.flag_in = 1;
    end else if (op == 8'h0F) begin
      if (k == 5) begin o.ar_out = 1; o.ram_out = 1; end
      if (k == 6) begin o.ram_out = 1; o.rin = 8'h04; o.acc_sel = 1; end
      if (k == 7) o.flag_in = 1;
    end else if (op == 8'h10) begin
      o.ar_out = 1; o.rout = 8'h04; o.ram_in = 1;
    end else if (op == 8'h11) begin
      if (ok) begin o.rout = s1h; o.rin = d1h; end
    end else if (op == 8'h12) begin
      if (k == 5 && ok) begin o.rout = s1h; o.rin = 8'h04; o.acc_sel = 1; end
      if (k == 6) o.flag_in = 1;
    end else if (op == 8'h13) begin
      if (k == 5) begin o.ar_out = 1; o.rin = 8'h04; o.acc_sel = 1; end
      if (k == 6) o.flag_in = 1;
    end else if (take) begin
      o.ar_out = 1; o.pc_in = 1;
    end
    return o;
  endfunction

  task automatic run_instr(input logic [7:0] op, input logic [7:0] opnd, input logic [3:0] f,
                           input int stall_at, input int stall_n, input int abort_at,
                           input bit rnd_stall);
    int len = ilen(op, opnd);
    for (int k = 0; k < len; k++) begin
      int ns = (k == stall_at) ? stall_n : ((rnd_stall && $urandom_range(0, 7) == 0) ? 1 : 0);
      for (int s = 0; s < ns; s++) begin
        @(negedge clk);
        cpu_run = 1'b0; opcode = op; operand = opnd; {Z, N, C, V} = f;
        #1 check_eq($sformatf("stall op%02h k%0d", op, k), 64'(observe()), 64'(model(op, opnd, f, k, 0)));
      end
      @(negedge clk);
      cpu_run = 1'b1; opcode = op; operand = opnd; {Z, N, C, V} = f;
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1 check_eq("reset_abort", 64'(observe()), 64'(0));
        return;
      end
      #1 check_eq($sformatf("op%02h opnd%02h k%0d", op, opnd, k), 64'(observe()),
                  64'(model(op, opnd, f, k, 1)));
    end
  endtask

  task automatic release_reset();
    obs_t e;
    @(negedge clk);
    rst_n = 1'b1; cpu_run = 1'b1;
    e = '0; e.pc_out = 1; e.mar_in = 1;
    #1 check_eq("post_reset_step0", 64'(observe()), 64'(e));
    cpu_run = 1'b0;
  endtask

  initial begin
    obs_t e;
    logic [7:0] op, opnd;
    rst_n = 1'b0; cpu_run = 1'b0; opcode = 8'h00; operand = '0; {Z, N, C, V} = 4'h0;
    #1 check_eq("reset_state", 64'(observe()), 64'(0));
    repeat (2) @(negedge clk);
    release_reset();

    run_instr(8'h00, 8'b01_011_001, 4'h0, -1, 0, -1, 0);   // ADD R3 <- R1
    run_instr(8'h15, 8'h00, 4'b0000, -1, 0, -1, 0);        // JZ not taken
    run_instr(8'h15, 8'h00, 4'b1000, -1, 0, -1, 0);        // JZ taken
    run_instr(8'h0F, 8'h40, 4'h0, 6, 3, -1, 0);            // LOAD, stalled at step 6
    run_instr(8'h3F, 8'h00, 4'h0, -1, 0, -1, 0);
    run_instr(8'h12, 8'b10_000_101, 4'h0, -1, 0, -1, 0);   // bad-mode MOV C,R

    for (int i = 0; i < 80; i++) begin
      op = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 31));
      if (op == 8'h0E) op = 8'h0D;
      opnd = 8'($urandom);
      if ($urandom_range(0, 3) != 0) opnd[7:6] = 2'b01;
      run_instr(op, opnd, 4'($urandom), -1, 0, -1, 1);
    end

    run_instr(8'h00, 8'b01_011_001, 4'h0, -1, 0, 6, 0);    // reset mid-step 6 of ADD
    @(negedge clk);
    #1 check_eq("reset_hold", 64'(observe()), 64'(0));
    release_reset();

    run_instr(8'h0E, 8'h00, 4'h0, -1, 0, -1, 0);
    e = '0; e.stp = 4'd5; e.halt = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cpu_run = 1'b1; opcode = 8'($urandom); operand = 8'($urandom);
      #1 check_eq($sformatf("halted c%0d", i), 64'(observe()), 64'(e));
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_eq("halt_reset", 64'(observe()), 64'(0));
    release_reset();
    run_instr(8'h0D, 8'h00, 4'h0, -1, 0, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
